command_word_sequencer: RTL and testbench

COMMAND_WORD_SEQUENCER -- requirements
Module: command_word_sequencer

---
 rtl/command_word_sequencer_pkg.sv | 32 +++
 rtl/command_word_sequencer_decoder.sv | 24 ++
 rtl/command_word_sequencer.sv | 154 +++++++++++++++
 tb/tb_command_word_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/command_word_sequencer_pkg.sv
// Shared types and field positions for the command word sequencer.
// Optional poll support is enabled with the CMD_SEQ_POLL_EN macro.
package command_word_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_READY     = 2'd0,
        ST_WAIT_ICW2 = 2'd1,
        ST_WAIT_ICW3 = 2'd2,
        ST_WAIT_ICW4 = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        CMD_ICW1    = 2'd0,
        CMD_OCW2    = 2'd1,
        CMD_OCW3    = 2'd2,
        CMD_A0_HIGH = 2'd3
    } cmd_class_t;

    localparam int ICW1_IC4_BIT   = 0;
    localparam int ICW1_SNGL_BIT  = 1;
    localparam int ICW1_CFG_MSB   = 3;
    localparam int ICW2_VEC_LSB   = 3;
    localparam int ICW4_CFG_MSB   = 4;
    localparam int OCW3_RIS_BIT   = 0;
    localparam int OCW3_RR_BIT    = 1;
    localparam int OCW3_POLL_BIT  = 2;
    localparam int OCW3_SMM_BIT   = 5;
    localparam int OCW3_ESMM_BIT  = 6;

    localparam logic [7:0] RESET_MASK = 8'hFF;

endpackage

// File: rtl/command_word_sequencer_decoder.sv
// Combinational classifier of a CPU write into ICW1 / OCW2 / OCW3 / A0-high.
module command_word_decoder
    import command_word_sequencer_pkg::*;
(
    input  logic       address,
    input  logic [1:0] data_d4_d3,
    output cmd_class_t cmd_class
);

    // A0 dominates; with A0 low, D4 marks ICW1 and D3 splits OCW3 from OCW2
    always_comb begin
        cmd_class = CMD_OCW2;
        if (address) begin
            cmd_class = CMD_A0_HIGH;
        end else if (data_d4_d3[1]) begin
            cmd_class = CMD_ICW1;
        end else if (data_d4_d3[0]) begin
            cmd_class = CMD_OCW3;
        end else begin
            cmd_class = CMD_OCW2;
        end
    end

endmodule

// File: rtl/command_word_sequencer.sv
// Initialization/operation command word sequencer for an 8259-style controller.
// Define CMD_SEQ_POLL_EN to enable the OCW3 poll command pulse.
module command_word_sequencer
    import command_word_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       write_strobe,
    input  logic       address,
    input  logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       initialized,
    output logic [3:0] icw1_config,
    output logic [4:0] interrupt_vector_address,
    output logic [7:0] cascade_device_config,
    output logic [4:0] icw4_config,
    output logic [7:0] interrupt_mask,
    output logic       enable_read_register,
    output logic       read_register_isr_or_irr,
    output logic       special_mask_mode,
    output logic       poll_command
);

    cmd_class_t w_cmd_class;
    seq_state_t r_state;
    logic       w_ocw_ok;

    command_word_decoder u_decoder (
        .address    (address),
        .data_d4_d3 (internal_data_bus[4:3]),
        .cmd_class  (w_cmd_class)
    );

    assign w_ocw_ok = (r_state == ST_READY) && initialized;

    // Sequencer state, one-cycle strobes and latched configuration
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state                        <= ST_READY;
            initialized                    <= 1'b0;
            write_initial_command_word_1   <= 1'b0;
            write_initial_command_word_2   <= 1'b0;
            write_initial_command_word_3   <= 1'b0;
            write_initial_command_word_4   <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
            write_operation_control_word_2 <= 1'b0;
            write_operation_control_word_3 <= 1'b0;
            icw1_config                    <= 4'h0;
            interrupt_vector_address       <= 5'h00;
            cascade_device_config          <= 8'h00;
            icw4_config                    <= 5'h00;
            interrupt_mask                 <= RESET_MASK;
            enable_read_register           <= 1'b1;
            read_register_isr_or_irr       <= 1'b0;
            special_mask_mode              <= 1'b0;
            poll_command                   <= 1'b0;
        end else begin
            write_initial_command_word_1   <= 1'b0;
            write_initial_command_word_2   <= 1'b0;
            write_initial_command_word_3   <= 1'b0;
            write_initial_command_word_4   <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
            write_operation_control_word_2 <= 1'b0;
            write_operation_control_word_3 <= 1'b0;
            poll_command                   <= 1'b0;
            if (write_strobe) begin
                case (w_cmd_class)
                    CMD_ICW1: begin
                        write_initial_command_word_1 <= 1'b1;
                        r_state                      <= ST_WAIT_ICW2;
                        icw1_config                  <= internal_data_bus[ICW1_CFG_MSB:0];
                        initialized                  <= 1'b0;
                        interrupt_mask               <= 8'h00;
                        enable_read_register         <= 1'b1;
                        read_register_isr_or_irr     <= 1'b0;
                        special_mask_mode            <= 1'b0;
                        if (!internal_data_bus[ICW1_IC4_BIT]) begin
                            icw4_config <= 5'h00;
                        end
                    end
                    CMD_A0_HIGH: begin
                        case (r_state)
                            ST_WAIT_ICW2: begin
                                write_initial_command_word_2 <= 1'b1;
                                interrupt_vector_address     <= internal_data_bus[7:ICW2_VEC_LSB];
                                if (!icw1_config[ICW1_SNGL_BIT]) begin
                                    r_state <= ST_WAIT_ICW3;
                                end else if (icw1_config[ICW1_IC4_BIT]) begin
                                    r_state <= ST_WAIT_ICW4;
                                end else begin
                                    r_state     <= ST_READY;
                                    initialized <= 1'b1;
                                end
                            end
                            ST_WAIT_ICW3: begin
                                write_initial_command_word_3 <= 1'b1;
                                cascade_device_config        <= internal_data_bus;
                                if (icw1_config[ICW1_IC4_BIT]) begin
                                    r_state <= ST_WAIT_ICW4;
                                end else begin
                                    r_state     <= ST_READY;
                                    initialized <= 1'b1;
                                end
                            end
                            ST_WAIT_ICW4: begin
                                write_initial_command_word_4 <= 1'b1;
                                icw4_config                  <= internal_data_bus[ICW4_CFG_MSB:0];
                                r_state                      <= ST_READY;
                                initialized                  <= 1'b1;
                            end
                            ST_READY: begin
                                if (initialized) begin
                                    write_operation_control_word_1 <= 1'b1;
                                    interrupt_mask                 <= internal_data_bus;
                                end
                            end
                            default: r_state <= ST_READY;
                        endcase
                    end
                    CMD_OCW2: begin
                        if (w_ocw_ok) begin
                            write_operation_control_word_2 <= 1'b1;
                        end
                    end
                    CMD_OCW3: begin
                        if (w_ocw_ok) begin
                            write_operation_control_word_3 <= 1'b1;
                            if (internal_data_bus[OCW3_RR_BIT]) begin
                                enable_read_register     <= 1'b1;
                                read_register_isr_or_irr <= internal_data_bus[OCW3_RIS_BIT];
                            end else begin
                                enable_read_register <= 1'b0;
                            end
                            if (internal_data_bus[OCW3_ESMM_BIT]) begin
                                special_mask_mode <= internal_data_bus[OCW3_SMM_BIT];
                            end
`ifdef CMD_SEQ_POLL_EN
                            poll_command <= internal_data_bus[OCW3_POLL_BIT];
`endif
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_command_word_sequencer.sv
// Self-checking bench: directed init scenarios plus randomized writes against a queue-based model.
module tb_command_word_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       write_strobe = 1'b0;
    logic       address = 1'b0;
    logic [7:0] internal_data_bus = 8'h00;
    logic       icw1_stb, icw2_stb, icw3_stb, icw4_stb;
    logic       ocw1_stb, ocw2_stb, ocw3_stb;
    logic       initialized;
    logic [3:0] icw1_config;
    logic [4:0] interrupt_vector_address;
    logic [7:0] cascade_device_config;
    logic [4:0] icw4_config;
    logic [7:0] interrupt_mask;
    logic       enable_read_register, read_register_isr_or_irr, special_mask_mode, poll_command;

    always #5 clock = ~clock;

    command_word_sequencer dut (
        .clock                          (clock),
        .reset                          (reset),
        .write_strobe                   (write_strobe),
        .address                        (address),
        .internal_data_bus              (internal_data_bus),
        .write_initial_command_word_1   (icw1_stb),
        .write_initial_command_word_2   (icw2_stb),
        .write_initial_command_word_3   (icw3_stb),
        .write_initial_command_word_4   (icw4_stb),
        .write_operation_control_word_1 (ocw1_stb),
        .write_operation_control_word_2 (ocw2_stb),
        .write_operation_control_word_3 (ocw3_stb),
        .initialized                    (initialized),
        .icw1_config                    (icw1_config),
        .interrupt_vector_address       (interrupt_vector_address),
        .cascade_device_config          (cascade_device_config),
        .icw4_config                    (icw4_config),
        .interrupt_mask                 (interrupt_mask),
        .enable_read_register           (enable_read_register),
        .read_register_isr_or_irr       (read_register_isr_or_irr),
        .special_mask_mode              (special_mask_mode),
        .poll_command                   (poll_command)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the words still owed after ICW1 are kept as a queue of ICW numbers
    int         m_pending[$];
    logic       m_init;
    logic [3:0] m_icw1;
    logic [4:0] m_vec;
    logic [7:0] m_cas;
    logic [4:0] m_icw4;
    logic [7:0] m_mask;
    logic       m_err, m_ris, m_smm, m_poll;
    logic [4:1] m_icw_stb;
    logic [3:1] m_ocw_stb;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_apply(input logic rst, input logic ws, input logic a0, input logic [7:0] d);
        int w;
        m_icw_stb = 4'b0000;
        m_ocw_stb = 3'b000;
        m_poll    = 1'b0;
        if (rst) begin
            m_pending.delete();
            m_init = 1'b0; m_icw1 = 4'h0; m_vec = 5'h00; m_cas = 8'h00; m_icw4 = 5'h00;
            m_mask = 8'hFF; m_err = 1'b1; m_ris = 1'b0; m_smm = 1'b0;
        end else if (ws) begin
            if (!a0 && d[4]) begin
                m_icw_stb[1] = 1'b1;
                m_icw1 = d[3:0];
                m_init = 1'b0; m_mask = 8'h00; m_err = 1'b1; m_ris = 1'b0; m_smm = 1'b0;
                if (!d[0]) m_icw4 = 5'h00;
                m_pending.delete();
                m_pending.push_back(2);
                if (!d[1]) m_pending.push_back(3);
                if (d[0]) m_pending.push_back(4);
            end else if (m_pending.size() > 0) begin
                if (a0) begin
                    w = m_pending.pop_front();
                    m_icw_stb[w] = 1'b1;
                    if (w == 2) m_vec = d[7:3];
                    else if (w == 3) m_cas = d;
                    else m_icw4 = d[4:0];
                    if (m_pending.size() == 0) m_init = 1'b1;
                end
            end else if (m_init) begin
                if (a0) begin
                    m_ocw_stb[1] = 1'b1;
                    m_mask = d;
                end else if (!d[3]) begin
                    m_ocw_stb[2] = 1'b1;
                end else begin
                    m_ocw_stb[3] = 1'b1;
                    if (d[1]) begin m_err = 1'b1; m_ris = d[0]; end
                    else m_err = 1'b0;
                    if (d[6]) m_smm = d[5];
`ifdef CMD_SEQ_POLL_EN
                    m_poll = d[2];
`endif
                end
            end
        end
    endtask

    task automatic check_all();
        check_eq("icw_strobes", {28'h0, icw4_stb, icw3_stb, icw2_stb, icw1_stb}, {28'h0, m_icw_stb});
        check_eq("ocw_strobes", {29'h0, ocw3_stb, ocw2_stb, ocw1_stb}, {29'h0, m_ocw_stb});
        check_eq("initialized", {31'h0, initialized}, {31'h0, m_init});
        check_eq("icw1_config", {28'h0, icw1_config}, {28'h0, m_icw1});
        check_eq("vector", {27'h0, interrupt_vector_address}, {27'h0, m_vec});
        check_eq("cascade", {24'h0, cascade_device_config}, {24'h0, m_cas});
        check_eq("icw4_config", {27'h0, icw4_config}, {27'h0, m_icw4});
        check_eq("mask", {24'h0, interrupt_mask}, {24'h0, m_mask});
        check_eq("ocw3_fields", {29'h0, enable_read_register, read_register_isr_or_irr, special_mask_mode},
                 {29'h0, m_err, m_ris, m_smm});
        check_eq("poll", {31'h0, poll_command}, {31'h0, m_poll});
    endtask

    task automatic step(input logic rst, input logic ws, input logic a0, input logic [7:0] d);
        reset = rst; write_strobe = ws; address = a0; internal_data_bus = d;
        @(posedge clock);
        #1;
        model_apply(rst, ws, a0, d);
        check_all();
        reset = 1'b0; write_strobe = 1'b0;
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        step(1'b0, 1'b1, a0, d);
    endtask

    initial begin
        logic       r_rst, r_ws, r_a0;
        logic [7:0] r_d;

        step(1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("rst_mask", {24'h0, interrupt_mask}, 32'h0000_00FF);
        check_eq("rst_err", {31'h0, enable_read_register}, 32'h1);

        // OCW1 before initialization is dropped
        wr(1'b1, 8'hA5);
        check_eq("pre_init_mask", {24'h0, interrupt_mask}, 32'h0000_00FF);

        // Single-chip init with ICW4
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h20);
        check_eq("single_no_init_yet", {31'h0, initialized}, 32'h0);
        wr(1'b1, 8'h01);
        check_eq("single_init", {31'h0, initialized}, 32'h1);
        check_eq("single_vec", {27'h0, interrupt_vector_address}, 32'h04);
        check_eq("single_icw4", {27'h0, icw4_config}, 32'h01);

        wr(1'b1, 8'hA5);
        check_eq("ocw1_mask", {24'h0, interrupt_mask}, 32'h0000_00A5);
        check_eq("ocw1_stb", {31'h0, ocw1_stb}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("ocw1_stb_drop", {31'h0, ocw1_stb}, 32'h0);

        wr(1'b0, 8'h0C);
`ifdef CMD_SEQ_POLL_EN
        check_eq("ocw3_poll", {31'h0, poll_command}, 32'h1);
`else
        check_eq("ocw3_poll", {31'h0, poll_command}, 32'h0);
`endif
        wr(1'b0, 8'h0B);
        check_eq("ocw3_ris", {31'h0, read_register_isr_or_irr}, 32'h1);

        // Cascade init: initialized only after ICW4
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h08);
        wr(1'b1, 8'h04);
        check_eq("casc_not_init", {31'h0, initialized}, 32'h0);
        wr(1'b1, 8'h03);
        check_eq("casc_cfg", {24'h0, cascade_device_config}, 32'h04);
        check_eq("casc_aeoi", {31'h0, icw4_config[1]}, 32'h1);
        check_eq("casc_init", {31'h0, initialized}, 32'h1);

        // ICW1 mid-sequence restarts; old ICW3 value kept
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h08);
        wr(1'b0, 8'h13);
        check_eq("restart_mask", {24'h0, interrupt_mask}, 32'h00);
        check_eq("restart_cas", {24'h0, cascade_device_config}, 32'h04);
        wr(1'b1, 8'h20);
        check_eq("restart_icw2", {31'h0, icw2_stb}, 32'h1);
        wr(1'b1, 8'h01);

        // Reset wins over a coincident ICW2 write
        wr(1'b0, 8'h13);
        step(1'b1, 1'b1, 1'b1, 8'h20);
        check_eq("rst_icw2_vec", {27'h0, interrupt_vector_address}, 32'h0);
        check_eq("rst_icw2_stb", {31'h0, icw2_stb}, 32'h0);
        wr(1'b1, 8'h20);
        check_eq("rst_icw2_after", {27'h0, interrupt_vector_address}, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 99) < 2);
            r_ws  = ($urandom_range(0, 3) != 0);
            r_a0  = $urandom_range(0, 1);
            r_d   = 8'($urandom);
            if (!r_a0 && r_d[4] && ($urandom_range(0, 3) != 0)) r_d[4] = 1'b0;
            step(r_rst, r_ws, r_a0, r_d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
